// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I load/store unit. It takes the ALU result as the
// effective address and performs one word-addressed access over a valid/ready bus.
// Stores get lane steering and strobes; loads get lane extraction and extension.
// The core is stalled while an operation is in flight.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err_misaligned,
    output logic        err_illegal,
    output logic        err_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t state, state_next;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] load_q;
    logic [2:0]  funct3_q;
    logic        store_q;
    logic [3:0]  wstrb_q;
    logic [TW-1:0] timer_q;
    logic        err_mis_q;
    logic        err_ill_q;
    logic        err_bus_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic [31:0] steer_wdata;
    logic [3:0]  steer_wstrb;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] ext_data;
    logic        timeout_hit;

    // Decode the incoming request: legality, alignment, and store lane steering.
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        steer_wdata    = req_wdata;
        steer_wstrb    = 4'b1111;
        if (req_store)
            req_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            req_illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
        case (req_funct3[1:0])
            2'b00: begin
                steer_wdata = {4{req_wdata[7:0]}};
                steer_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                steer_wdata    = {2{req_wdata[15:0]}};
                steer_wstrb    = 4'b0011 << {req_addr[1], 1'b0};
                req_misaligned = req_addr[0];
            end
            default: begin
                req_misaligned = |req_addr[1:0];
            end
        endcase
        if (!req_store)
            steer_wstrb = 4'b0000;
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        byte_lane = mem_rdata[7:0];
        case (addr_q[1:0])
            2'b01:   byte_lane = mem_rdata[15:8];
            2'b10:   byte_lane = mem_rdata[23:16];
            2'b11:   byte_lane = mem_rdata[31:24];
            default: byte_lane = mem_rdata[7:0];
        endcase
        half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ext_data = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  ext_data = {{16{half_lane[15]}}, half_lane};
            3'b100:  ext_data = {24'd0, byte_lane};
            3'b101:  ext_data = {16'd0, half_lane};
            default: ext_data = mem_rdata;
        endcase
    end

    assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // State register; reset drops straight to IDLE so mem_req falls asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: rejected requests skip the bus and go straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_next = (req_illegal || req_misaligned) ? DONE : ACCESS;
            end
            ACCESS: begin
                if (mem_ready || timeout_hit)
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latching, wait counting, and result/error capture on the way into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            load_q    <= '0;
            funct3_q  <= '0;
            store_q   <= 1'b0;
            wstrb_q   <= '0;
            timer_q   <= '0;
            err_mis_q <= 1'b0;
            err_ill_q <= 1'b0;
            err_bus_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        err_ill_q <= req_illegal;
                        err_mis_q <= !req_illegal && req_misaligned;
                        err_bus_q <= 1'b0;
                        timer_q   <= '0;
                        if (req_illegal || req_misaligned) begin
                            load_q <= '0;
                        end else begin
                            addr_q   <= req_addr;
                            funct3_q <= req_funct3;
                            store_q  <= req_store;
                            wdata_q  <= steer_wdata;
                            wstrb_q  <= steer_wstrb;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        load_q <= store_q ? 32'd0 : ext_data;
                    end else if (timeout_hit) begin
                        err_bus_q <= 1'b1;
                        load_q    <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign mem_req        = (state == ACCESS);
    assign mem_we         = mem_req & store_q;
    assign mem_addr       = {addr_q[31:2], 2'b00};
    assign mem_wstrb      = mem_req ? wstrb_q : 4'b0000;
    assign mem_wdata      = wdata_q;
    assign load_data      = load_q;
    assign err_misaligned = err_mis_q;
    assign err_illegal    = err_ill_q;
    assign err_bus        = err_bus_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus random operations compared
// against an arithmetic reference model of the load/store rules.
module tb_load_store_unit;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        err_misaligned;
    logic        err_illegal;
    logic        err_bus;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] cap_addr, cap_wdata, cap_load;
    logic [3:0]  cap_wstrb;
    logic        cap_we, cap_mis, cap_ill, cap_bus;
    int          cap_done_k, cap_req_cnt, cap_busy_cnt;
    logic        have_prev_load;
    logic [31:0] prev_load;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .busy           (busy),
        .done           (done),
        .load_data      (load_data),
        .err_misaligned (err_misaligned),
        .err_illegal    (err_illegal),
        .err_bus        (err_bus),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wstrb      (mem_wstrb),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes for a legal funct3.
    function automatic int ref_size(input logic [2:0] f3);
        int code;
        code = int'(f3) % 4;
        return (code == 0) ? 1 : (code == 1) ? 2 : 4;
    endfunction

    function automatic logic ref_illegal(input logic st, input logic [2:0] f3);
        if (st) return (f3 > 3'd2);
        return (f3 == 3'd3) || (f3 >= 3'd6);
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % ref_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_strb(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int n;
        if (!st) return 4'd0;
        n = ref_size(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n;
        n = ref_size(f3);
        if (n == 1) return (wd % 256) * 32'h0101_0101;
        if (n == 2) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n;
        longint val;
        longint span;
        n = ref_size(f3);
        if (n == 4) return rd;
        span = longint'(1) << (8 * n);
        val  = longint'(rd >> (8 * (a % 4))) % span;
        if (f3 < 3'd4 && val >= span / 2) val = val - span;
        return 32'(val);
    endfunction

    // Run one operation from the IDLE cycle through done and check it against the model.
    // delay < 0 means mem_ready is never given.
    task automatic apply_stimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd, input int delay);
        logic exp_ill, exp_mis, exp_err;
        int   exp_req, exp_done_k, mem_bad;
        logic [31:0] exp_load;
        @(negedge clk);
        if (have_prev_load) begin
            check_output("load_hold", load_data, prev_load);
            check_output("done_low_after", {31'd0, done}, 32'd0);
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        mem_rdata  = rd;
        mem_ready  = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        exp_ill = ref_illegal(st, f3);
        exp_mis = !exp_ill && ref_misaligned(f3, a);
        exp_err = exp_ill || exp_mis;
        exp_req = exp_err ? 0 : (delay < 0 ? T : delay + 1);
        exp_done_k = exp_req + 1;
        exp_load = (exp_err || st || delay < 0) ? 32'd0 : ref_load(f3, a, rd);
        cap_req_cnt = 0; cap_busy_cnt = 0; cap_done_k = 0; mem_bad = 0;
        for (int k = 1; k <= T + 8; k++) begin
            if (busy) cap_busy_cnt++;
            if (done) begin
                cap_done_k = k;
                cap_load = load_data;
                cap_mis = err_misaligned;
                cap_ill = err_illegal;
                cap_bus = err_bus;
                check_output("mem_req_in_done", {31'd0, mem_req}, 32'd0);
                break;
            end
            if (mem_req) begin
                cap_req_cnt++;
                if (cap_req_cnt == 1) begin
                    cap_addr = mem_addr; cap_wdata = mem_wdata;
                    cap_wstrb = mem_wstrb; cap_we = mem_we;
                end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
                             mem_wstrb !== cap_wstrb || mem_we !== cap_we) begin
                    mem_bad++;
                end
                mem_ready = (delay >= 0) && (cap_req_cnt > delay);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check_output("done_cycle", cap_done_k, exp_done_k);
        check_output("req_cycles", cap_req_cnt, exp_req);
        check_output("busy_cycles", cap_busy_cnt, exp_done_k);
        check_output("err_illegal", {31'd0, cap_ill}, {31'd0, exp_ill});
        check_output("err_misaligned", {31'd0, cap_mis}, {31'd0, exp_mis});
        check_output("err_bus", {31'd0, cap_bus}, {31'd0, (!exp_err && delay < 0)});
        if (!st || exp_err) check_output("load_data", cap_load, exp_load);
        if (!exp_err) begin
            check_output("mem_addr", cap_addr, {a[31:2], 2'b00});
            check_output("mem_we", {31'd0, cap_we}, {31'd0, st});
            check_output("mem_wstrb", {28'd0, cap_wstrb}, {28'd0, ref_strb(st, f3, a)});
            if (st) check_output("mem_wdata", cap_wdata, ref_wdata(f3, wd));
            check_output("mem_stable", mem_bad, 0);
        end
        have_prev_load = !st || exp_err;
        prev_load = cap_load;
    endtask

    initial begin
        int done_seen;
        have_prev_load = 1'b0;
        prev_load  = '0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        @(negedge clk);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_done", {31'd0, done}, 32'd0);
        check_output("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_output("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_output("rst_errs", {29'd0, err_misaligned, err_illegal, err_bus}, 32'd0);
        check_output("rst_mem_addr", mem_addr, 32'd0);
        check_output("rst_mem_wdata", mem_wdata, 32'd0);
        check_output("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check_output("rst_load_data", load_data, 32'd0);
        rst = 1'b0;

        apply_stimulus(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0);
        check_output("sb_addr", cap_addr, 32'h0000_1000);
        check_output("sb_wstrb", {28'd0, cap_wstrb}, 32'h8);
        check_output("sb_wdata", cap_wdata, 32'hDDDD_DDDD);
        check_output("sb_done_k", cap_done_k, 2);

        apply_stimulus(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_80FF, 0);
        check_output("lb_value", cap_load, 32'hFFFF_FF80);
        apply_stimulus(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_80FF, 0);
        check_output("lbu_value", cap_load, 32'h0000_0080);
        apply_stimulus(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 0);
        check_output("lh_value", cap_load, 32'hFFFF_8001);
        apply_stimulus(1'b0, 3'b010, 32'h0000_2002, 32'h0, 32'h8001_0000, 0);
        check_output("lw_mis_flag", {31'd0, cap_mis}, 32'd1);
        check_output("lw_mis_done_k", cap_done_k, 1);
        check_output("lw_mis_no_req", cap_req_cnt, 0);

        apply_stimulus(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 3);
        check_output("lw_wait_busy", cap_busy_cnt, 5);
        check_output("lw_wait_value", cap_load, 32'hDEAD_BEEF);

        apply_stimulus(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h1111_2222, -1);
        check_output("to_req_cycles", cap_req_cnt, 16);
        check_output("to_err_bus", {31'd0, cap_bus}, 32'd1);
        check_output("to_load_zero", cap_load, 32'd0);

        // Reset in the second ACCESS cycle of a load that never completes.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0000_5000; req_wdata = 32'h0; mem_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_output("mid_req_before_rst", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check_output("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_output("mid_rst_done", {31'd0, done}, 32'd0);
        check_output("mid_rst_mem_addr", mem_addr, 32'd0);
        check_output("mid_rst_load", load_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check_output("mid_rst_no_done", done_seen, 0);
        have_prev_load = 1'b0;

        apply_stimulus(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0);
        check_output("sw_wstrb", {28'd0, cap_wstrb}, 32'hF);
        check_output("sw_wdata", cap_wdata, 32'hCAFE_F00D);
        apply_stimulus(1'b0, 3'b011, 32'h0000_0020, 32'h0, 32'h0, 0);
        check_output("ill_flag", {31'd0, cap_ill}, 32'd1);

        for (int i = 0; i < 60; i++) begin
            logic        st;
            logic [2:0]  f3;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            apply_stimulus(st, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
